alu_seq: RTL and testbench

Parametrised, clocked successor to the combinational datapath ALU. It performs add, sub, and/or/not in one cycle. Multiply and divide are iterative, one bit per clock, instead of large combinational arrays. It uses a start/busy/done handshake, registers the result, remainder and N/Z/C/V flags, and sits between the register-file read stage and the writeback/flag register of the processor datapath.

---
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide (one bit per clock) behind a start/busy/done handshake.
module alu_seq #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   selec_alu,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] remainder,
    output logic         Neg,
    output logic         Z,
    output logic         C,
    output logic         V
);

    localparam int unsigned CW = $clog2(N) + 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpNot = 3'b110;

    typedef enum logic [1:0] {StIdle, StIter, StFinish} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic           is_div_q, is_div_d;
    logic [N-1:0]   result_q, result_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           neg_q, neg_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic           done_q, done_d;

    logic [N:0]     add_sum, sub_sum;
    logic [N:0]     mul_sum;
    logic [N:0]     div_sh, div_diff;
    logic           div_ge;
    logic [N-1:0]   step_hi, step_lo;

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);

    // Multiply: hi:lo holds partial product above the unconsumed multiplier bits.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_sh   = {hi_q, lo_q[N-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[N];

    always_comb begin
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
            step_lo = {lo_q[N-2:0], div_ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_q[N-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        result_d = result_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle, StFinish: begin
                state_d = StIdle;
                if (start) begin
                    if (selec_alu == OpMul || (selec_alu == OpDiv && b != '0)) begin
                        state_d  = StIter;
                        cnt_d    = '0;
                        hi_d     = '0;
                        is_div_d = (selec_alu == OpDiv);
                        lo_d     = (selec_alu == OpDiv) ? a : b;
                        opnd_d   = (selec_alu == OpDiv) ? b : a;
                    end else begin
                        done_d = 1'b1;
                        rem_d  = '0;
                        neg_d  = 1'b0;
                        c_d    = 1'b0;
                        v_d    = 1'b0;
                        case (selec_alu)
                            OpAdd: begin
                                result_d = add_sum[N-1:0];
                                c_d      = add_sum[N];
                                neg_d    = add_sum[N-1];
                                v_d      = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
                            end
                            OpSub: begin
                                result_d = sub_sum[N-1:0];
                                c_d      = sub_sum[N];
                                neg_d    = sub_sum[N-1];
                                v_d      = (a[N-1] != b[N-1]) && (sub_sum[N-1] != a[N-1]);
                            end
                            OpDiv: begin
                                result_d = '1;
                                rem_d    = a;
                                v_d      = 1'b1;
                            end
                            OpAnd:   result_d = a & b;
                            OpOr:    result_d = a | b;
                            OpNot:   result_d = ~a;
                            default: result_d = '0;
                        endcase
                    end
                end
            end
            StIter: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = step_hi;
                lo_d  = step_lo;
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = StFinish;
                    done_d   = 1'b1;
                    result_d = step_lo;
                    rem_d    = is_div_q ? step_hi : '0;
                    c_d      = is_div_q ? 1'b0 : (step_hi != '0);
                    neg_d    = 1'b0;
                    v_d      = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done_d) begin
            z_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == StIter);
    assign done      = done_q;
    assign result    = result_q;
    assign remainder = rem_q;
    assign Neg       = neg_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N=8) with hand-computed expectations.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic [2:0] selec_alu;
    logic       busy, done;
    logic [7:0] result, remainder;
    logic       Neg, Z, C, V;

    int n_checks = 0;
    int n_errors = 0;
    int cyc, bcyc;

    alu_seq #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .selec_alu (selec_alu),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .Neg       (Neg),
        .Z         (Z),
        .C         (C),
        .V         (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, count cycles to done and busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                          output int cycles, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; a = x; b = y; selec_alu = op;
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); selec_alu = 3'($urandom);
        cycles = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
        end while (!done && cycles < 40);
    endtask

    function automatic logic [3:0] flags();
        return {Neg, Z, C, V};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; selec_alu = '0;
        #1;
        chk("reset_result", result, 8'h00);
        chk("reset_ctl", {busy, done, Neg, Z, C, V}, 6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // add FF+01
        run_op(3'b000, 8'hFF, 8'h01, cyc, bcyc);
        chk("add_lat", cyc, 1);
        chk("add_res", result, 8'h00);
        chk("add_flg", flags(), 4'b0110);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("add_hold", result, 8'h00);

        // sub
        run_op(3'b001, 8'h80, 8'h01, cyc, bcyc);
        chk("sub1_res", result, 8'h7F);
        chk("sub1_flg", flags(), 4'b0011);
        run_op(3'b001, 8'h03, 8'h05, cyc, bcyc);
        chk("sub2_res", result, 8'hFE);
        chk("sub2_flg", flags(), 4'b1000);

        // mul
        run_op(3'b010, 8'd20, 8'd13, cyc, bcyc);
        chk("mul1_lat", cyc, 9);
        chk("mul1_busy", bcyc, 8);
        chk("mul1_res", result, 8'h04);
        chk("mul1_flg", flags(), 4'b0010);
        chk("mul1_rem", remainder, 8'h00);
        run_op(3'b010, 8'd15, 8'd15, cyc, bcyc);
        chk("mul2_res", result, 8'hE1);
        chk("mul2_flg", flags(), 4'b0000);

        // div
        run_op(3'b011, 8'd200, 8'd7, cyc, bcyc);
        chk("div_lat", cyc, 9);
        chk("div_res", result, 8'd28);
        chk("div_rem", remainder, 8'd4);
        chk("div_flg", flags(), 4'b0000);
        run_op(3'b011, 8'd5, 8'd0, cyc, bcyc);
        chk("div0_lat", cyc, 1);
        chk("div0_res", result, 8'hFF);
        chk("div0_rem", remainder, 8'h05);
        chk("div0_flg", flags(), 4'b0001);

        // logic ops and reserved
        run_op(3'b100, 8'hF0, 8'h3C, cyc, bcyc);
        chk("and_res", result, 8'h30);
        chk("and_rem", remainder, 8'h00);
        run_op(3'b101, 8'hF0, 8'h3C, cyc, bcyc);
        chk("or_res", result, 8'hFC);
        run_op(3'b110, 8'hF0, 8'h3C, cyc, bcyc);
        chk("not_res", result, 8'h0F);
        chk("not_flg", flags(), 4'b0000);
        run_op(3'b111, 8'h12, 8'h34, cyc, bcyc);
        chk("rsv_res", result, 8'h00);
        chk("rsv_flg", flags(), 4'b0100);

        // start held through a mul with changing operands; re-accept in done cycle
        @(negedge clk);
        start = 1'b1; a = 8'd20; b = 8'd13; selec_alu = 3'b010;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done) begin
                a = 8'($urandom); b = 8'($urandom);
            end
        end while (!done && cyc < 40);
        chk("hs_lat", cyc, 9);
        chk("hs_res1", result, 8'h04);
        a = 8'd15; b = 8'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs_busy2", busy, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        chk("hs_lat2", cyc, 9);
        chk("hs_res2", result, 8'hE1);

        // reset during a div
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd7; selec_alu = 3'b011;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_res", result, 8'h00);
        chk("rst_mid_ctl", {busy, done, Neg, Z, C, V, remainder}, 14'b0);
        cyc = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cyc++;
        end
        chk("rst_no_done", cyc, 0);
        rst_n = 1'b1;
        run_op(3'b000, 8'd3, 8'd4, cyc, bcyc);
        chk("post_rst_lat", cyc, 1);
        chk("post_rst_res", result, 8'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
